// File: rtl/uart_rx.sv
//==============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with 2-flop input synchroniser, start-bit
//            validation, mid-bit sampling and one-cycle valid/frame-error strobes.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx #(
    parameter int CLK_PER_BIT = 87,
    parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy,
    output logic [1:0] o_state
);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_START = 2'b01;
    localparam logic [1:0] c_DATA  = 2'b11;
    localparam logic [1:0] c_STOP  = 2'b10;

    localparam logic [CNT_W-1:0] c_HALF = CNT_W'((CLK_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic             r_rx_meta;
    logic             r_rx_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             w_cnt_last;

    // Both flops reset high so a reset never fabricates a start bit.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_cnt_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= 3'd0;
                    if (!r_rx_s) begin
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (r_cnt == c_HALF) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_s ? c_IDLE : c_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                c_DATA: begin
                    if (w_cnt_last) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rx_s;
                        if (r_idx == 3'd7) begin
                            r_idx   <= 3'd0;
                            r_state <= c_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                c_STOP: begin
                    // Returning to IDLE at mid-stop lets a back-to-back start bit be caught.
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                        if (r_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= 3'd0;
                end
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != c_IDLE);
    assign o_state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//==============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx using a timing-arithmetic model.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int H    = (CPB - 1) / 2;
    localparam int MAXC = 4096;

    logic       clk;
    logic       i_rst_n;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;
    logic [1:0] o_state;

    uart_rx #(
        .CLK_PER_BIT(CPB),
        .CNT_W      (3)
    ) u_dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy),
        .o_state    (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         cyc;
    bit         rx_h  [MAXC];
    bit         rst_h [MAXC];
    bit         rxs_h [MAXC];
    int         m_t;
    logic [7:0] m_data;
    int         total;
    int         bad;
    int         n_valid;
    int         n_err;
    int         first_busy;
    int         vcyc [8];
    logic [7:0] vdat [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_valid    = 0;
        n_err      = 0;
        first_busy = -1;
    endtask

    // Frame timing expressed as offsets from t0, the first cycle the synchronised line is low while idle.
    task automatic model_and_compare();
        logic       exp_valid;
        logic       exp_err;
        logic [1:0] exp_state;
        logic [7:0] b;
        int         j;
        int         d;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (rst_h[cyc] || rst_h[cyc-1]) begin
            m_t    = -1;
            m_data = 8'h00;
        end else begin
            j = cyc - 1;
            if (m_t < 0) begin
                if (!rxs_h[j]) m_t = j;
            end else begin
                d = j - m_t;
                if (d == 1 + H && rxs_h[j]) begin
                    m_t = -1;
                end else if (d == 1 + H + 9 * CPB) begin
                    if (rxs_h[j]) begin
                        for (int i = 0; i < 8; i++)
                            b[i] = rxs_h[m_t + 1 + H + (i + 1) * CPB];
                        m_data    = b;
                        exp_valid = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                    end
                    m_t = -1;
                end
            end
        end
        if (m_t < 0) begin
            exp_state = 2'b00;
        end else begin
            d = cyc - m_t;
            if (d <= H + 1)                exp_state = 2'b01;
            else if (d <= H + 1 + 8 * CPB) exp_state = 2'b11;
            else                           exp_state = 2'b10;
        end
        check("valid", o_valid, exp_valid);
        check("frame_err", o_frame_err, exp_err);
        check("data", o_data, m_data);
        check("state", o_state, exp_state);
        check("busy", o_busy, exp_state != 2'b00);
        if (o_valid) begin
            if (n_valid < 8) begin
                vcyc[n_valid] = cyc;
                vdat[n_valid] = o_data;
            end
            n_valid++;
        end
        if (o_frame_err) n_err++;
        if (o_busy && first_busy < 0) first_busy = cyc;
    endtask

    task automatic tick(input bit rx_v, input bit rst_v);
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        #1;
        i_rx    = rx_v;
        i_rst_n = !rst_v;
        rx_h[cyc]  = rx_v;
        rst_h[cyc] = rst_v;
        rxs_h[cyc] = (cyc < 2 || rst_h[cyc] || rst_h[cyc-1] || rst_h[cyc-2]) ? 1'b1 : rx_h[cyc-2];
        @(negedge clk);
        model_and_compare();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] v, input bit stop_v);
        repeat (CPB) tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            repeat (CPB) tick(v[i], 1'b0);
        repeat (CPB) tick(stop_v, 1'b0);
    endtask

    int s;

    initial begin
        cyc      = 0;
        total    = 0;
        bad      = 0;
        m_t      = -1;
        m_data   = 8'h00;
        i_rst_n  = 1'b0;
        i_rx     = 1'b1;
        rx_h[0]  = 1'b1;
        rst_h[0] = 1'b1;
        rxs_h[0] = 1'b1;
        clear_stats();

        repeat (4) tick(1'b1, 1'b1);
        check("rst_data", o_data, 8'h00);
        check("rst_state", o_state, 2'b00);
        check("rst_busy", o_busy, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        idle(8);

        // Single byte: strobe at t0+77, t0 = first low cycle + 2.
        clear_stats();
        s = cyc + 1;
        send_frame(8'hA5, 1'b1);
        idle(16);
        check("a5_count", n_valid, 1);
        check("a5_cycle", vcyc[0], s + 79);
        check("a5_data", vdat[0], 8'hA5);
        check("a5_err", n_err, 0);
        check("a5_busy_start", first_busy, s + 3);

        clear_stats();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(16);
        check("b2b_count", n_valid, 2);
        check("b2b_gap", vcyc[1] - vcyc[0], 80);
        check("b2b_data0", vdat[0], 8'h00);
        check("b2b_data1", vdat[1], 8'hFF);

        clear_stats();
        s = cyc + 1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        idle(16);
        check("glitch_busy_seen", first_busy, s + 3);
        check("glitch_valid", n_valid, 0);
        check("glitch_err", n_err, 0);
        check("glitch_state", o_state, 2'b00);
        check("glitch_data", o_data, 8'hFF);

        clear_stats();
        send_frame(8'h5A, 1'b1);
        send_frame(8'h3C, 1'b0);
        idle(24);
        check("ferr_valid", n_valid, 1);
        check("ferr_count", n_err, 1);
        check("ferr_data_first", vdat[0], 8'h5A);
        check("ferr_data_hold", o_data, 8'h5A);

        // Abort 0x81 partway through bit 4.
        clear_stats();
        repeat (CPB) tick(1'b0, 1'b0);
        repeat (CPB) tick(1'b1, 1'b0);
        repeat (3 * CPB) tick(1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        check("abort_in_data", o_state, 2'b11);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("abort_rst_data", o_data, 8'h00);
        check("abort_rst_state", o_state, 2'b00);
        check("abort_rst_busy", o_busy, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        idle(16);
        check("abort_valid", n_valid, 0);
        check("abort_err", n_err, 0);
        clear_stats();
        send_frame(8'h42, 1'b1);
        idle(16);
        check("after_rst_count", n_valid, 1);
        check("after_rst_data", o_data, 8'h42);

        clear_stats();
        repeat (30 * CPB) tick(1'b0, 1'b0);
        idle(2);
        check("break_errs", n_err, 3);
        check("break_valid", n_valid, 0);
        idle(15 * CPB);
        clear_stats();
        send_frame(8'h99, 1'b1);
        idle(16);
        check("post_break_count", n_valid, 1);
        check("post_break_data", o_data, 8'h99);
        check("post_break_err", n_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx.
- Line format: 8N1, LSB first, idle-high line, same CLK_PER_BIT bit timing as uart_tx.
- Synchronises the asynchronous serial input, detects and validates the start bit, and samples each bit at its centre.
- Presents each received byte with a one-cycle valid strobe, or a one-cycle framing-error strobe; sits between the board RX pin and the byte consumer.

Parameters:
- CLK_PER_BIT, default 87, clk cycles per bit (e.g. 10 MHz / 115200); legal range 4..65535.
- CNT_W, default $clog2(CLK_PER_BIT), width of the bit-period counter.

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  reset
- i_rx  in  1  serial line, asynchronous to clk, idle high
- o_data  out  8  last correctly received byte
- o_valid  out  1  one-cycle pulse: o_data updated
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_busy  out  1  high whenever state != IDLE
- o_state  out  2  current FSM state, for debug

Interface: one clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is i_rst_n.
- All logic uses posedge clk with asynchronous clear on negedge i_rst_n.

Behaviour:
- Synchroniser:
  - 2-flop synchroniser i_rx -> rx_s; both flops reset to 1.
  - Only rx_s is used internally.
- Reset values:
  - o_data=0, o_valid=0, o_frame_err=0, o_busy=0, o_state=IDLE.
  - Bit counter=0, bit index=0, shift register=0.
- State encoding: IDLE=2'b00, START=2'b01, DATA=2'b11, STOP=2'b10. Any other value goes to IDLE.
- H = (CLK_PER_BIT-1)/2, integer divide.
- IDLE:
  - cnt=0, idx=0.
  - If rx_s==0: go to START.
- START:
  - cnt increments each cycle.
  - When cnt==H: if rx_s==0, go to DATA with cnt=0; else go to IDLE (glitch rejected, no strobe).
- DATA:
  - cnt increments up to CLK_PER_BIT-1.
  - At cnt==CLK_PER_BIT-1: shift[idx]<=rx_s, cnt<=0.
  - If idx==7: idx<=0 and go to STOP; else idx<=idx+1.
- STOP:
  - cnt increments up to CLK_PER_BIT-1.
  - At cnt==CLK_PER_BIT-1, go to IDLE. If rx_s==1: o_data<=shift and o_valid<=1. Else: o_frame_err<=1 and o_data is left unchanged.
  - IDLE is entered at mid-stop-bit, so a start bit immediately after the stop bit is accepted.
- Strobes:
  - o_valid and o_frame_err are registered and high for exactly one cycle; never both high.
- Latency:
  - Let t0 be the first cycle IDLE sees rx_s==0. o_valid/o_frame_err is high at cycle t0 + 2 + H + 9*CLK_PER_BIT.
  - rx_s lags i_rx by 2 cycles.
- Break (line held low):
  - Frame ends with o_frame_err.
  - IDLE then sees rx_s==0 and starts a new frame; each break frame repeats the frame error. No lock-up.
- o_data holds its value between frames. No overrun detection; the consumer must take o_data within one frame time.
- Reset mid-frame:
  - Immediate return to IDLE; no strobe for the aborted frame.
  - After release, reception resumes on the next falling edge of rx_s.

Test Plan (CLK_PER_BIT=8, so H=3):
- Send 0xA5 8N1 at 8 clk/bit -> o_valid single-cycle pulse at t0+77, o_data=0xA5, o_frame_err=0, o_busy high from t0+1 until the strobe cycle.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two o_valid pulses 80 cycles apart, o_data=0x00 then 0xFF.
- Pull i_rx low for 2 cycles only -> START aborts at cnt==3, o_state returns to 00, no strobes, o_data unchanged.
- Send 0x3C with stop bit driven 0, after a prior good 0x5A -> o_frame_err pulse, o_valid=0, o_data stays 0x5A.
- Assert i_rst_n low during DATA bit 4 of 0x81, release, then send 0x42 -> no strobe for 0x81, all outputs at reset values during reset, then o_data=0x42 with o_valid.
- Hold i_rx low for 30 bit times, then high, then send 0x99 -> repeated o_frame_err pulses and no o_valid during the break, then o_data=0x99 with o_valid.
